pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 28 ++
 rtl/pipe_ctrl.sv | 90 +++++++++
 tb/tb_pipe_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the 5-stage pipeline datapath (master) and pipe_ctrl (slave).
// Signal names match the controller's port list one-for-one.
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             fs_req_valid;
  logic [4:0]       ready_go;
  logic             wb_out_allowin;
  logic             br_flush;
  logic             ex_flush;
  logic             stat_clr;
  logic [4:0]       stage_valid;
  logic [4:0]       stage_allowin;
  logic [4:0]       stage_load;
  logic             fs_allowin;
  logic             retire;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output fs_req_valid, ready_go, wb_out_allowin, br_flush, ex_flush, stat_clr,
    input  stage_valid, stage_allowin, stage_load, fs_allowin, retire, stall_cnt
  );

  modport slave (
    input  fs_req_valid, ready_go, wb_out_allowin, br_flush, ex_flush, stat_clr,
    output stage_valid, stage_allowin, stage_load, fs_allowin, retire, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// 5-stage (IF/ID/EX/MEM/WB) valid/allowin pipeline controller with flush and fetch-stall counter.
// Zero added latency; backpressure ripples combinationally from wb_out_allowin back to fs_allowin.
module pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  pipe_ctrl_if.slave  pif
);

  logic [4:0]       valid_q;
  logic [4:0]       valid_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  logic [4:0] out_valid;
  logic [4:0] allowin;
  logic [4:0] in_valid;
  logic [4:0] kill;
  logic [4:0] load;
  logic       br_eff;
  logic       fs_allowin;

  always_comb begin
    out_valid = valid_q & pif.ready_go;

    // Allowin resolves from WB back to IF; no path feeds back toward WB.
    allowin    = '0;
    allowin[4] = !valid_q[4] | (pif.ready_go[4] & pif.wb_out_allowin);
    for (int i = 3; i >= 0; i--) begin
      allowin[i] = !valid_q[i] | (pif.ready_go[i] & allowin[i+1]);
    end

    // A branch flush only counts when EX actually holds the branch.
    br_eff = pif.br_flush & valid_q[2];

    in_valid = {out_valid[3:0], pif.fs_req_valid};
    if (br_eff) begin
      in_valid[2] = 1'b0;
    end

    if (pif.ex_flush) begin
      kill = 5'b11111;
    end else if (br_eff) begin
      kill = 5'b00011;
    end else begin
      kill = 5'b00000;
    end

    load       = allowin & in_valid & ~kill & {5{!reset}};
    fs_allowin = allowin[0] & !pif.ex_flush & !br_eff;
  end

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < 5; i++) begin
      if (allowin[i]) begin
        valid_d[i] = in_valid[i];
      end
    end
    valid_d = valid_d & ~kill;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pif.stat_clr) begin
      stall_cnt_d = '0;
    end else if (pif.fs_req_valid && !fs_allowin && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pif.stage_valid   = valid_q;
  assign pif.stage_allowin = allowin;
  assign pif.stage_load    = load;
  assign pif.fs_allowin    = fs_allowin;
  assign pif.retire        = out_valid[4] & pif.wb_out_allowin & !pif.ex_flush;
  assign pif.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: fill, backpressure, bubbles, flushes, reset and stall counter saturation.
module tb_pipe_ctrl;

  logic clk;
  logic reset;

  pipe_ctrl_if #(.CNT_W(16)) pif ();
  pipe_ctrl_if #(.CNT_W(4))  pif4 ();

  pipe_ctrl #(.CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .pif   (pif)
  );

  pipe_ctrl #(.CNT_W(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .pif   (pif4)
  );

  int n_checks;
  int n_errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] fill_exp [5];

  initial begin
    n_checks = 0;
    n_errors = 0;
    fill_exp[0] = 5'b00001;
    fill_exp[1] = 5'b00011;
    fill_exp[2] = 5'b00111;
    fill_exp[3] = 5'b01111;
    fill_exp[4] = 5'b11111;

    reset               = 1'b1;
    pif.fs_req_valid    = 1'b1;
    pif.ready_go        = 5'b11111;
    pif.wb_out_allowin  = 1'b1;
    pif.br_flush        = 1'b0;
    pif.ex_flush        = 1'b0;
    pif.stat_clr        = 1'b0;
    pif4.fs_req_valid   = 1'b1;
    pif4.ready_go       = 5'b11111;
    pif4.wb_out_allowin = 1'b0;
    pif4.br_flush       = 1'b0;
    pif4.ex_flush       = 1'b1;
    pif4.stat_clr       = 1'b0;
    #1;

    // Reset state
    chk("rst_valid",   32'(pif.stage_valid),   32'h00);
    chk("rst_allowin", 32'(pif.stage_allowin), 32'h1f);
    chk("rst_load",    32'(pif.stage_load),    32'h00);
    chk("rst_retire",  32'(pif.retire),        32'h0);
    chk("rst_stall",   32'(pif.stall_cnt),     32'h0);
    step();
    step();
    chk("rst_held_valid", 32'(pif.stage_valid), 32'h00);
    reset = 1'b0;
    #1;
    chk("post_rst_load",  32'(pif.stage_load), 32'h01);
    chk("post_rst_fsall", 32'(pif.fs_allowin), 32'h1);

    // Fill with no backpressure
    for (int k = 0; k < 5; k++) begin
      chk("fill_retire_pre", 32'(pif.retire), 32'h0);
      step();
      chk($sformatf("fill_valid_%0d", k + 1), 32'(pif.stage_valid), 32'(fill_exp[k]));
    end
    chk("fill_retire", 32'(pif.retire), 32'h1);
    chk("fill_stall",  32'(pif.stall_cnt), 32'h0);

    // WB sink stalls for 3 cycles
    pif.wb_out_allowin = 1'b0;
    #1;
    chk("bp_allowin", 32'(pif.stage_allowin), 32'h00);
    chk("bp_fsall",   32'(pif.fs_allowin),    32'h0);
    chk("bp_retire",  32'(pif.retire),        32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_valid", 32'(pif.stage_valid), 32'h1f);
    end
    pif.wb_out_allowin = 1'b1;
    #1;
    chk("bp_stall", 32'(pif.stall_cnt), 32'h3);

    // EX not ready for one cycle: bubble into MEM
    pif.ready_go = 5'b11011;
    #1;
    chk("bub_allowin", 32'(pif.stage_allowin), 32'h18);
    chk("bub_load",    32'(pif.stage_load),    32'h10);
    step();
    pif.ready_go = 5'b11111;
    #1;
    chk("bub_valid0", 32'(pif.stage_valid), 32'h17);
    step();
    chk("bub_valid1", 32'(pif.stage_valid), 32'h0f);
    step();
    chk("bub_valid2", 32'(pif.stage_valid), 32'h1f);
    chk("bub_stall",  32'(pif.stall_cnt),   32'h4);

    // Branch flush with EX valid
    pif.br_flush = 1'b1;
    #1;
    chk("br_fsall",  32'(pif.fs_allowin), 32'h0);
    chk("br_load",   32'(pif.stage_load), 32'h18);
    chk("br_retire", 32'(pif.retire),     32'h1);
    step();
    chk("br_valid", 32'(pif.stage_valid), 32'h18);

    // Branch flush with EX empty has no effect
    #1;
    chk("br_noeff_fsall", 32'(pif.fs_allowin), 32'h1);
    step();
    pif.br_flush = 1'b0;
    #1;
    chk("br_noeff_valid", 32'(pif.stage_valid), 32'h11);
    chk("br_stall",       32'(pif.stall_cnt),   32'h5);

    for (int k = 0; k < 4; k++) step();
    chk("refill_valid", 32'(pif.stage_valid), 32'h1f);

    // Exception and branch flush together
    pif.ex_flush = 1'b1;
    pif.br_flush = 1'b1;
    #1;
    chk("ex_retire", 32'(pif.retire),     32'h0);
    chk("ex_fsall",  32'(pif.fs_allowin), 32'h0);
    chk("ex_load",   32'(pif.stage_load), 32'h00);
    step();
    pif.ex_flush = 1'b0;
    pif.br_flush = 1'b0;
    #1;
    chk("ex_valid", 32'(pif.stage_valid), 32'h00);
    chk("ex_stall", 32'(pif.stall_cnt),   32'h6);

    pif.stat_clr = 1'b1;
    step();
    pif.stat_clr = 1'b0;
    #1;
    chk("clr_stall", 32'(pif.stall_cnt), 32'h0);

    // Reset mid-operation discards in-flight work
    step();
    step();
    chk("mid_valid_pre", 32'(pif.stage_valid), 32'h07);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(pif.stage_valid), 32'h00);
    chk("mid_rst_load",  32'(pif.stage_load),  32'h00);
    step();
    reset = 1'b0;
    pif.fs_req_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("mid_no_retire", 32'(pif.retire), 32'h0);
    end
    chk("mid_valid_post", 32'(pif.stage_valid), 32'h00);

    // Narrow counter saturates and clears under continued blocking
    pif4.stat_clr = 1'b1;
    step();
    pif4.stat_clr = 1'b0;
    #1;
    chk("sat_start", 32'(pif4.stall_cnt), 32'h0);
    for (int k = 0; k < 14; k++) step();
    chk("sat_14", 32'(pif4.stall_cnt), 32'd14);
    for (int k = 0; k < 6; k++) step();
    chk("sat_held", 32'(pif4.stall_cnt), 32'd15);
    pif4.stat_clr = 1'b1;
    step();
    pif4.stat_clr = 1'b0;
    #1;
    chk("sat_clr", 32'(pif4.stall_cnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
